// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the data-memory arbiter.
package mem_arb_pkg;
    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_P    = 2'd1,
        OWN_V    = 2'd2
    } owner_e;
endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and memory-side bus of the data-memory arbiter.
interface dmem_arbiter_if #(
    parameter int ADDR_W = mem_arb_pkg::ADDR_W_DEF,
    parameter int DATA_W = mem_arb_pkg::DATA_W_DEF
);
    logic              p_req;
    logic [ADDR_W-1:0] p_addr;
    logic [DATA_W-1:0] p_wdata;
    logic              p_wren;
    logic              p_gnt;
    logic              p_stall;
    logic              p_rvalid;
    logic [DATA_W-1:0] p_rdata;

    logic              v_req;
    logic [ADDR_W-1:0] v_addr;
    logic [DATA_W-1:0] v_wdata;
    logic              v_wren;
    logic              v_gnt;
    logic              v_rvalid;
    logic [DATA_W-1:0] v_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_q;

    // The arbiter side.
    modport slave (
        input  p_req, p_addr, p_wdata, p_wren,
        input  v_req, v_addr, v_wdata, v_wren,
        input  mem_q,
        output p_gnt, p_stall, p_rvalid, p_rdata,
        output v_gnt, v_rvalid, v_rdata,
        output mem_addr, mem_wdata, mem_wren
    );

    // The requesters plus memory, as seen from outside the arbiter.
    modport master (
        output p_req, p_addr, p_wdata, p_wren,
        output v_req, v_addr, v_wdata, v_wren,
        output mem_q,
        input  p_gnt, p_stall, p_rvalid, p_rdata,
        input  v_gnt, v_rvalid, v_rdata,
        input  mem_addr, mem_wdata, mem_wren
    );
endinterface

// File: rtl/arb_streak_ctr.sv
// Saturating up-counter with synchronous clear; tracks the VGA grant streak.
module arb_streak_ctr
    import mem_arb_pkg::*;
#(
    parameter int MAX_STREAK = 4,
    parameter int CW         = $clog2(MAX_STREAK + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          inc,
    input  logic          clr,
    output logic [CW-1:0] cnt
);
    logic [CW-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (inc && (cnt_q != CW'(MAX_STREAK)))
            cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/dmem_arbiter.sv
// Shares one dmem port between processor (P) and VGA fetcher (V); V has
// default priority, P is forced through after MAX_STREAK V grants.
module dmem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int MAX_STREAK = 4
) (
    input logic           clock,
    input logic           reset,
    dmem_arbiter_if.slave bus
);
    localparam int CW = $clog2(MAX_STREAK + 1);

    logic          p_gnt, v_gnt;
    logic          p_rvalid, v_rvalid;
    logic [CW-1:0] streak;
    logic          streak_max;
    owner_e        owner_d, owner_q;
    logic [DATA_W-1:0] p_rdata_d, p_rdata_q, v_rdata_d, v_rdata_q;

    assign streak_max = (streak == CW'(MAX_STREAK));

    always_comb begin
        p_gnt = 1'b0;
        v_gnt = 1'b0;
        if (!reset) begin
            if (bus.v_req && !(bus.p_req && streak_max)) v_gnt = 1'b1;
            else if (bus.p_req)                            p_gnt = 1'b1;
        end
    end

    // Streak only grows while P is actually being held off.
    arb_streak_ctr #(.MAX_STREAK(MAX_STREAK), .CW(CW)) u_streak (
        .clock (clock),
        .reset (reset),
        .inc   (v_gnt & bus.p_req),
        .clr   (p_gnt | ~bus.p_req),
        .cnt   (streak)
    );

    assign bus.p_gnt     = p_gnt;
    assign bus.v_gnt     = v_gnt;
    assign bus.p_stall   = bus.p_req & ~p_gnt;
    assign bus.mem_addr  = p_gnt ? bus.p_addr  : bus.v_addr;
    assign bus.mem_wdata = p_gnt ? bus.p_wdata : bus.v_wdata;
    assign bus.mem_wren  = (p_gnt & bus.p_wren) | (v_gnt & bus.v_wren);

    always_comb begin
        owner_d = OWN_NONE;
        if (p_gnt && !bus.p_wren)      owner_d = OWN_P;
        else if (v_gnt && !bus.v_wren) owner_d = OWN_V;
    end

    // Reset in the return cycle must kill the pending rvalid.
    assign p_rvalid = !reset && (owner_q == OWN_P);
    assign v_rvalid = !reset && (owner_q == OWN_V);

    always_comb begin
        p_rdata_d = p_rvalid ? bus.mem_q : p_rdata_q;
        v_rdata_d = v_rvalid ? bus.mem_q : v_rdata_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            owner_q   <= OWN_NONE;
            p_rdata_q <= '0;
            v_rdata_q <= '0;
        end else begin
            owner_q   <= owner_d;
            p_rdata_q <= p_rdata_d;
            v_rdata_q <= v_rdata_d;
        end
    end

    assign bus.p_rvalid = p_rvalid;
    assign bus.v_rvalid = v_rvalid;
    assign bus.p_rdata  = p_rvalid ? bus.mem_q : p_rdata_q;
    assign bus.v_rdata  = v_rvalid ? bus.mem_q : v_rdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with hand-computed expectations.
module tb_dmem_arbiter;
    logic clock = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_fail = 0;

    dmem_arbiter_if #(.ADDR_W(12), .DATA_W(32)) bus ();

    dmem_arbiter #(.ADDR_W(12), .DATA_W(32), .MAX_STREAK(4)) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.p_req = 1'b0; bus.p_addr = '0; bus.p_wdata = '0; bus.p_wren = 1'b0;
        bus.v_req = 1'b0; bus.v_addr = '0; bus.v_wdata = '0; bus.v_wren = 1'b0;
        bus.mem_q = '0;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        // Reset with both requesting: no grants, no write, P stalls.
        bus.p_req = 1'b1; bus.v_req = 1'b1; bus.v_wren = 1'b1; bus.p_wren = 1'b1;
        #1;
        chk("rst_gnt", {30'd0, bus.p_gnt, bus.v_gnt}, 32'd0);
        chk("rst_wren", {31'd0, bus.mem_wren}, 32'd0);
        chk("rst_stall", {31'd0, bus.p_stall}, 32'd1);
        tick(); tick();
        reset = 1'b0;
        idle();
        #1;
        chk("post_rst_rvalid", {30'd0, bus.p_rvalid, bus.v_rvalid}, 32'd0);
        chk("post_rst_prdata", bus.p_rdata, 32'd0);
        chk("post_rst_vrdata", bus.v_rdata, 32'd0);
        tick();

        // P-only read at 0x010.
        bus.p_req = 1'b1; bus.p_addr = 12'h010;
        #1;
        chk("p_rd_gnt", {30'd0, bus.p_gnt, bus.v_gnt}, 32'd2);
        chk("p_rd_stall", {31'd0, bus.p_stall}, 32'd0);
        chk("p_rd_addr", {20'd0, bus.mem_addr}, 32'h010);
        chk("p_rd_wren", {31'd0, bus.mem_wren}, 32'd0);
        tick();
        idle();
        bus.mem_q = 32'hDEADBEEF;
        #1;
        chk("p_rd_rvalid", {30'd0, bus.p_rvalid, bus.v_rvalid}, 32'd2);
        chk("p_rd_rdata", bus.p_rdata, 32'hDEADBEEF);
        tick();
        bus.mem_q = 32'h0;
        #1;
        chk("p_rd_rvalid_off", {30'd0, bus.p_rvalid, bus.v_rvalid}, 32'd0);
        chk("p_rd_hold", bus.p_rdata, 32'hDEADBEEF);
        tick();

        // Both requesting writes for 10 cycles: V,V,V,V,P,V,V,V,V,P.
        bus.p_req = 1'b1; bus.p_wren = 1'b1; bus.p_addr = 12'h0AA;
        bus.v_req = 1'b1; bus.v_wren = 1'b1; bus.v_addr = 12'h0BB;
        for (int i = 0; i < 10; i++) begin
            logic pw;
            pw = (i == 4) || (i == 9);
            #1;
            chk($sformatf("streak_gnt%0d", i), {30'd0, bus.p_gnt, bus.v_gnt}, pw ? 32'd2 : 32'd1);
            chk($sformatf("streak_stall%0d", i), {31'd0, bus.p_stall}, pw ? 32'd0 : 32'd1);
            chk($sformatf("streak_addr%0d", i), {20'd0, bus.mem_addr}, pw ? 32'h0AA : 32'h0BB);
            tick();
        end

        // V read 0x100 then P write 0x200.
        idle();
        bus.v_req = 1'b1; bus.v_addr = 12'h100;
        #1;
        chk("vp_c1_gnt", {30'd0, bus.p_gnt, bus.v_gnt}, 32'd1);
        chk("vp_c1_wren", {31'd0, bus.mem_wren}, 32'd0);
        chk("vp_c1_rvalid", {30'd0, bus.p_rvalid, bus.v_rvalid}, 32'd0);
        tick();
        idle();
        bus.p_req = 1'b1; bus.p_addr = 12'h200; bus.p_wdata = 32'h5; bus.p_wren = 1'b1;
        bus.mem_q = 32'h1234;
        #1;
        chk("vp_c2_gnt", {30'd0, bus.p_gnt, bus.v_gnt}, 32'd2);
        chk("vp_c2_wren", {31'd0, bus.mem_wren}, 32'd1);
        chk("vp_c2_addr", {20'd0, bus.mem_addr}, 32'h200);
        chk("vp_c2_wdata", bus.mem_wdata, 32'h5);
        chk("vp_c2_rvalid", {30'd0, bus.p_rvalid, bus.v_rvalid}, 32'd1);
        chk("vp_c2_vrdata", bus.v_rdata, 32'h1234);
        tick();
        idle();
        #1;
        chk("vp_c3_rvalid", {30'd0, bus.p_rvalid, bus.v_rvalid}, 32'd0);
        chk("vp_c3_wren", {31'd0, bus.mem_wren}, 32'd0);
        tick();

        // Contended V read grant (streak -> 1), then reset the next cycle.
        bus.v_req = 1'b1; bus.v_addr = 12'h040;
        bus.p_req = 1'b1; bus.p_wren = 1'b1;
        #1;
        chk("rr_gnt", {30'd0, bus.p_gnt, bus.v_gnt}, 32'd1);
        tick();
        reset = 1'b1;
        bus.v_wren = 1'b1;
        #1;
        chk("rr_rvalid", {30'd0, bus.p_rvalid, bus.v_rvalid}, 32'd0);
        chk("rr_rst_gnt", {30'd0, bus.p_gnt, bus.v_gnt}, 32'd0);
        chk("rr_rst_wren", {31'd0, bus.mem_wren}, 32'd0);
        chk("rr_rst_stall", {31'd0, bus.p_stall}, 32'd1);
        tick();
        reset = 1'b0;
        #1;
        chk("rr_vrdata_clr", bus.v_rdata, 32'd0);
        // Streak restarted at 0: four V grants before P.
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("rr_after_gnt%0d", i), {30'd0, bus.p_gnt, bus.v_gnt}, (i == 4) ? 32'd2 : 32'd1);
            chk($sformatf("rr_after_rvalid%0d", i), {30'd0, bus.p_rvalid, bus.v_rvalid}, 32'd0);
            tick();
        end

        // P toggling, V constant: V always wins.
        idle();
        bus.v_req = 1'b1; bus.v_wren = 1'b1; bus.p_wren = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.p_req = (i % 2) == 1;
            #1;
            chk($sformatf("alt_gnt%0d", i), {30'd0, bus.p_gnt, bus.v_gnt}, 32'd1);
            chk($sformatf("alt_stall%0d", i), {31'd0, bus.p_stall}, (i % 2 == 1) ? 32'd1 : 32'd0);
            tick();
        end

        // No requests: idle bus, mem_addr follows V port.
        idle();
        bus.v_addr = 12'h333; bus.v_wren = 1'b1; bus.p_wren = 1'b1; bus.p_addr = 12'h444;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("idle_gnt%0d", i), {30'd0, bus.p_gnt, bus.v_gnt}, 32'd0);
            chk($sformatf("idle_wren%0d", i), {31'd0, bus.mem_wren}, 32'd0);
            chk($sformatf("idle_rvalid%0d", i), {30'd0, bus.p_rvalid, bus.v_rvalid}, 32'd0);
            chk($sformatf("idle_addr%0d", i), {20'd0, bus.mem_addr}, 32'h333);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
